// File: rtl/md5_controller.sv
// rtl/md5_controller.sv - brute-force lowercase MD5 search engine with iterative single-block core
// Odometer candidate generator feeding a one-step-per-cycle MD5 round, stopping on a digest match.

module md5_controller #(
  parameter int MAX_LEN = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   increment,
  input  logic [7:0]   startingPosition,
  input  logic [127:0] target_hash,
  output logic         enable,
  output logic         hashes_equal,
  output logic [127:0] hashed_password,
  output logic [127:0] plaintext
);

  typedef enum logic [2:0] {S_INIT, S_LOAD, S_HASH, S_FINAL, S_DONE} state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t         state_q, state_d;
  logic [4:0]     len_q, len_d, len_next;
  logic [127:0]   pt_q, pt_d, pt_next, pt_shift;
  logic [127:0]   hash_q, hash_d, digest;
  logic [511:0]   blk_q, blk_d, blk_v;
  logic [31:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [31:0]    f, sum, rot;
  logic [5:0]     step_q, step_d;
  logic [4:0]     shamt;
  logic [3:0]     g;
  logic           equal_q, equal_d, match, exhausted, carry;
  logic [7:0]     start_v;
  logic [2:0]     inc_v;
  logic [8:0]     sum0;

  assign start_v = (startingPosition >= 8'h61 && startingPosition <= 8'h7a) ? startingPosition : 8'h61;
  assign inc_v   = (increment == 3'd0) ? 3'd1 : increment;
  assign digest  = {bswap(a_q + IV_A), bswap(b_q + IV_B), bswap(c_q + IV_C), bswap(d_q + IV_D)};
  assign match   = (digest == target_hash);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_HASH;
      S_HASH:  if (step_q == 6'd63) state_d = S_FINAL;
      S_FINAL: state_d = (match || exhausted) ? S_DONE : S_LOAD;
      default: state_d = S_DONE;
    endcase
  end

  always_comb begin
    enable          = (state_q == S_LOAD) || (state_q == S_HASH) || (state_q == S_FINAL);
    hashes_equal    = equal_q;
    hashed_password = hash_q;
    plaintext       = pt_q;
  end

  // Padded block: first character is message byte 0, i.e. the highest used plaintext byte.
  always_comb begin
    blk_v    = '0;
    pt_shift = '0;
    for (int i = 0; i < 56; i++) begin
      if (i < int'(len_q)) begin
        pt_shift = pt_q >> (8 * (int'(len_q) - 1 - i));
        blk_v[i*8 +: 8] = pt_shift[7:0];
      end else if (i == int'(len_q)) begin
        blk_v[i*8 +: 8] = 8'h80;
      end
    end
    blk_v[448 +: 64] = {56'd0, len_q, 3'd0};
  end

  always_comb begin
    f = '0;
    g = '0;
    unique case (step_q[5:4])
      2'd0: begin f = (b_q & c_q) | (~b_q & d_q); g = step_q[3:0]; end
      2'd1: begin f = (d_q & b_q) | (~d_q & c_q); g = step_q[3:0] * 4'd5 + 4'd1; end
      2'd2: begin f = b_q ^ c_q ^ d_q;            g = step_q[3:0] * 4'd3 + 4'd5; end
      default: begin f = c_q ^ (b_q | ~d_q);      g = step_q[3:0] * 4'd7; end
    endcase
    unique case ({step_q[5:4], step_q[1:0]})
      4'h0: shamt = 5'd7;   4'h1: shamt = 5'd12;  4'h2: shamt = 5'd17;  4'h3: shamt = 5'd22;
      4'h4: shamt = 5'd5;   4'h5: shamt = 5'd9;   4'h6: shamt = 5'd14;  4'h7: shamt = 5'd20;
      4'h8: shamt = 5'd4;   4'h9: shamt = 5'd11;  4'ha: shamt = 5'd16;  4'hb: shamt = 5'd23;
      4'hc: shamt = 5'd6;   4'hd: shamt = 5'd10;  4'he: shamt = 5'd15;  default: shamt = 5'd21;
    endcase
    sum = a_q + f + K_TAB[step_q] + blk_q[{g, 5'd0} +: 32];
    rot = (sum << shamt) | (sum >> (6'd32 - {1'b0, shamt}));
  end

  // Odometer: byte 0 steps by the increment, higher bytes step through 'a'..'z'.
  always_comb begin
    carry     = 1'b0;
    exhausted = 1'b0;
    pt_next   = pt_q;
    len_next  = len_q;
    sum0      = {1'b0, pt_q[7:0]} + {6'd0, inc_v};
    if (sum0 > 9'h07a) begin
      pt_next[7:0] = start_v;
      carry        = 1'b1;
    end else begin
      pt_next[7:0] = sum0[7:0];
    end
    for (int j = 1; j < 16; j++) begin
      if (carry && j < int'(len_q)) begin
        if (pt_q[j*8 +: 8] >= 8'h7a) begin
          pt_next[j*8 +: 8] = 8'h61;
        end else begin
          pt_next[j*8 +: 8] = pt_q[j*8 +: 8] + 8'd1;
          carry             = 1'b0;
        end
      end
    end
    if (carry) begin
      if (len_q >= 5'(MAX_LEN)) begin
        exhausted = 1'b1;
      end else begin
        len_next = len_q + 5'd1;
        pt_next  = '0;
        for (int j = 0; j < 16; j++) begin
          if (j <= int'(len_q)) pt_next[j*8 +: 8] = 8'h61;
        end
        pt_next[7:0] = start_v;
      end
    end
  end

  always_comb begin
    len_d   = len_q;
    pt_d    = pt_q;
    hash_d  = hash_q;
    blk_d   = blk_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    step_d  = step_q;
    equal_d = equal_q;
    unique case (state_q)
      S_INIT: begin
        len_d = 5'd1;
        pt_d  = {120'd0, start_v};
      end
      S_LOAD: begin
        blk_d  = blk_v;
        a_d    = IV_A;
        b_d    = IV_B;
        c_d    = IV_C;
        d_d    = IV_D;
        step_d = 6'd0;
      end
      S_HASH: begin
        a_d    = d_q;
        b_d    = b_q + rot;
        c_d    = b_q;
        d_d    = c_q;
        step_d = step_q + 6'd1;
      end
      S_FINAL: begin
        hash_d = digest;
        if (match) begin
          equal_d = 1'b1;
        end else if (!exhausted) begin
          pt_d  = pt_next;
          len_d = len_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q   <= '0;
      pt_q    <= '0;
      hash_q  <= '0;
      blk_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      step_q  <= '0;
      equal_q <= 1'b0;
    end else begin
      len_q   <= len_d;
      pt_q    <= pt_d;
      hash_q  <= hash_d;
      blk_q   <= blk_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      step_q  <= step_d;
      equal_q <= equal_d;
    end
  end

endmodule

// File: tb/tb_md5_controller.sv
// tb/tb_md5_controller.sv - scoreboard bench for md5_controller against a string-level MD5 model
`timescale 1ns/1ps

module tb_md5_controller;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [2:0]   increment = 3'd1;
  logic [7:0]   startingPosition = 8'h61;
  logic [127:0] target_hash = '0;
  logic         enable, hashes_equal;
  logic [127:0] hashed_password, plaintext;

  md5_controller dut (
    .clk(clk), .reset(reset), .increment(increment), .startingPosition(startingPosition),
    .target_hash(target_hash), .enable(enable), .hashes_equal(hashes_equal),
    .hashed_password(hashed_password), .plaintext(plaintext)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  cyc;
    logic [127:0] digest;
    logic [127:0] pt_after;
    logic         eq;
    logic         en;
  } exp_t;

  exp_t         exp_q[$];
  int           tests = 0;
  int           fails = 0;
  int unsigned  cyc = 0;
  logic [127:0] prev_hash = '0;

  always @(posedge clk) begin
    if (!reset) cyc = 0;
    else        cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sine-derived round constants, as in RFC 1321.
  function automatic logic [31:0] k_of(input int i);
    real r;
    r = $sin(real'(i + 1));
    if (r < 0.0) r = -r;
    return 32'(longint'($floor(r * 4294967296.0)));
  endfunction

  function automatic int s_of(input int i);
    case (i / 16)
      0: case (i % 4) 0: return 7; 1: return 12; 2: return 17; default: return 22; endcase
      1: case (i % 4) 0: return 5; 1: return 9;  2: return 14; default: return 20; endcase
      2: case (i % 4) 0: return 4; 1: return 11; 2: return 16; default: return 23; endcase
      default: case (i % 4) 0: return 6; 1: return 10; 2: return 15; default: return 21; endcase
    endcase
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    logic [63:0] y;
    y = {x, x} << s;
    return y[63:32];
  endfunction

  // MD5 of the candidate whose text is len bytes, first character in the highest used byte.
  function automatic logic [127:0] md5_ref(input logic [127:0] pt, input int len);
    logic [7:0]   blk [64];
    logic [31:0]  m [16];
    logic [31:0]  h [4];
    logic [31:0]  a, b, c, d, f, t, w;
    logic [127:0] sh, out;
    logic [63:0]  bits;
    int           g;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < len; i++) begin
      sh = pt >> (8 * (len - 1 - i));
      blk[i] = sh[7:0];
    end
    blk[len] = 8'h80;
    bits = 64'(len) * 64'd8;
    for (int i = 0; i < 8; i++) blk[56 + i] = bits[8*i +: 8];
    for (int i = 0; i < 16; i++) m[i] = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
    h[0] = 32'h67452301; h[1] = 32'hefcdab89; h[2] = 32'h98badcfe; h[3] = 32'h10325476;
    a = h[0]; b = h[1]; c = h[2]; d = h[3];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0:       begin f = (b & c) | (~b & d); g = i;               end
        1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      endcase
      t = a + f + k_of(i) + m[g];
      a = d; d = c; c = b;
      b = b + rotl(t, s_of(i));
    end
    h[0] += a; h[1] += b; h[2] += c; h[3] += d;
    out = '0;
    for (int n = 0; n < 16; n++) begin
      w = h[n / 4] >> (8 * (n % 4));
      out[127 - 8*n -: 8] = w[7:0];
    end
    return out;
  endfunction

  // k-th candidate as a mixed-radix number: last char has n0 values, others 26.
  function automatic void cand_at(input longint k, input int sv, input int iv,
                                  output logic [127:0] pt, output int len);
    longint n0, cnt, q;
    int     last;
    n0  = (122 - sv) / iv + 1;
    cnt = n0;
    len = 1;
    while (k >= cnt && len < 16) begin
      k   = k - cnt;
      len = len + 1;
      cnt = cnt * 26;
    end
    last = sv + iv * int'(k % n0);
    q    = k / n0;
    pt   = '0;
    pt[7:0] = 8'(last);
    for (int j = 1; j < len; j++) begin
      pt[8*j +: 8] = 8'(97 + int'(q % 26));
      q = q / 26;
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_hash = '0;
    end else if (hashed_password !== prev_hash) begin
      prev_hash = hashed_password;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_digest: got %h expected none", hashed_password);
      end else begin
        e = exp_q.pop_front();
        chk("digest_cycle", 128'(cyc), 128'(e.cyc));
        chk("digest", hashed_password, e.digest);
        chk("plaintext_after", plaintext, e.pt_after);
        chk("hashes_equal", 128'(hashes_equal), 128'(e.eq));
        chk("enable_after", 128'(enable), 128'(e.en));
      end
    end
  end

  task automatic run_search(input logic [7:0] sp, input logic [2:0] inc,
                            input logic [127:0] tgt, input int max_c);
    int           sv, iv, len, len_n;
    logic [127:0] pt, pt_n, dg, hit_pt, hit_dg, first_pt;
    bit           hit;
    exp_t         e;
    int unsigned  bound;
    sv  = (sp >= 8'h61 && sp <= 8'h7a) ? int'(sp) : 97;
    iv  = (inc == 3'd0) ? 1 : int'(inc);
    hit = 1'b0;
    hit_pt = '0;
    hit_dg = '0;
    reset = 1'b0;
    startingPosition = sp;
    increment = inc;
    target_hash = tgt;
    repeat (2) @(negedge clk);
    chk("reset_enable", 128'(enable), 128'(0));
    chk("reset_equal", 128'(hashes_equal), 128'(0));
    chk("reset_hash", hashed_password, '0);
    chk("reset_plaintext", plaintext, '0);
    cand_at(0, sv, iv, first_pt, len);
    for (int k = 0; k < max_c && !hit; k++) begin
      cand_at(longint'(k), sv, iv, pt, len);
      cand_at(longint'(k) + 1, sv, iv, pt_n, len_n);
      dg = md5_ref(pt, len);
      e.cyc      = 67 + 66 * k;
      e.digest   = dg;
      e.eq       = (dg == tgt);
      e.en       = !e.eq;
      e.pt_after = e.eq ? pt : pt_n;
      if (e.eq) begin
        hit    = 1'b1;
        hit_pt = pt;
        hit_dg = dg;
      end
      exp_q.push_back(e);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("init_enable", 128'(enable), 128'(1));
    chk("init_plaintext", plaintext, first_pt);
    chk("init_equal", 128'(hashes_equal), 128'(0));
    bound = 67 + 66 * max_c + 10;
    while (exp_q.size() != 0 && cyc < bound) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL digest_timeout: got %0d of %0d digests", max_c - exp_q.size(), max_c);
      exp_q.delete();
    end
    if (hit) begin
      repeat (70) @(negedge clk);
      chk("done_equal", 128'(hashes_equal), 128'(1));
      chk("done_enable", 128'(enable), 128'(0));
      chk("done_plaintext", plaintext, hit_pt);
      chk("done_hash", hashed_password, hit_dg);
    end
  endtask

  task automatic mid_reset(input logic [7:0] sp, input logic [2:0] inc);
    int guard;
    reset = 1'b0;
    startingPosition = sp;
    increment = inc;
    target_hash = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    guard = 0;
    while (cyc < 32 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_enable_before", 128'(enable), 128'(1));
    #1 reset = 1'b0;
    #1;
    chk("mid_enable", 128'(enable), 128'(0));
    chk("mid_plaintext", plaintext, '0);
    chk("mid_equal", 128'(hashes_equal), 128'(0));
    chk("mid_hash", hashed_password, '0);
    run_search(sp, inc, 128'h0, 2);
  endtask

  localparam logic [127:0] MD5_A   = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] MD5_B   = 128'h92eb5ffee6ae2fec3ad71c777531578f;
  localparam logic [127:0] MD5_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;

  initial begin
    logic [7:0]   sp;
    logic [2:0]   inc;
    logic [127:0] tgt, pt;
    int           sv, iv, len, kt;
    run_search(8'h61, 3'd1, MD5_A, 1);
    run_search(8'h61, 3'd1, MD5_B, 2);
    run_search(8'h61, 3'd1, MD5_ABC, 731);
    run_search(8'h62, 3'd2, MD5_A, 16);
    mid_reset(8'h63, 3'd1);
    for (int r = 0; r < 3; r++) begin
      sp  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(97 + $urandom_range(0, 25));
      inc = 3'($urandom_range(0, 7));
      sv  = (sp >= 8'h61 && sp <= 8'h7a) ? int'(sp) : 97;
      iv  = (inc == 3'd0) ? 1 : int'(inc);
      if ($urandom_range(0, 3) == 0) begin
        tgt = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        kt = $urandom_range(0, 12);
        cand_at(longint'(kt), sv, iv, pt, len);
        tgt = md5_ref(pt, len);
      end
      run_search(sp, inc, tgt, 14);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
